// File: rtl/i2c_config_seq.sv
// Register-table sequencer: streams {reg addr, data} entries from a zero-latency
// table to an I2C byte master, one transaction per entry, with watchdog and retry.
module i2c_config_seq #(
   parameter int         NUM_REGS       = 306,
   parameter int         REG_ADDR_BYTES = 2,
   parameter int         ROM_AW         = 10,
   parameter logic [6:0] DEV_ADDR       = 7'h3C,
   parameter int         GAP_CYCLES     = 16,
   parameter int         TIMEOUT_CYCLES = 65535,
   parameter int         MAX_RETRY      = 3
) (
   input  logic              r_sysclk,
   input  logic              r_arst,
   input  logic              i_start,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_error,
   output logic [8:0]        o_reg_cnt,
   output logic [ROM_AW-1:0] o_rom_addr,
   input  logic [7:0]        i_rom_data,
   output logic              o_m_en,
   output logic              o_m_wr,
   output logic              o_last,
   output logic [6:0]        o_addr,
   output logic [7:0]        o_data,
   input  logic              i_ack
);

   typedef enum logic [2:0] {IDLE, XFER, GAP, DONE, ERROR} state_t;

   localparam int               ENTRY_B    = REG_ADDR_BYTES + 1;
   localparam int               WD_W       = (TIMEOUT_CYCLES <= 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam int               GAP_W      = (GAP_CYCLES <= 2) ? 1 : $clog2(GAP_CYCLES);
   localparam logic [1:0]       BYTE_LAST  = 2'(ENTRY_B - 1);
   localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
   localparam logic [3:0]       RETRY_LAST = 4'(MAX_RETRY - 1);
   localparam logic [8:0]       NUM_REGS_C = 9'(NUM_REGS);

   state_t            state_q, state_d;
   logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [8:0]        reg_cnt_q, reg_cnt_d;
   logic [3:0]        retry_cnt_q, retry_cnt_d;
   logic [WD_W-1:0]   wdog_q, wdog_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic              last_q, last_d;

   logic              entry_end;
   logic              timeout;
   logic              gap_end;
   logic [ROM_AW-1:0] rewind_addr;

   // An ack arriving in the watchdog's final cycle wins over the timeout.
   assign entry_end   = i_ack && (byte_cnt_q == BYTE_LAST);
   assign timeout     = !i_ack && (wdog_q == WD_LAST);
   assign gap_end     = (gap_q == GAP_LAST);
   assign rewind_addr = ROM_AW'(reg_cnt_q * ENTRY_B);

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge r_sysclk or posedge r_arst) begin
      if (r_arst) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE, ERROR: if (i_start) state_d = XFER;
         XFER: begin
            if (entry_end)    state_d = GAP;
            else if (timeout) state_d = (retry_cnt_q == RETRY_LAST) ? ERROR : GAP;
         end
         GAP: if (gap_end) state_d = (reg_cnt_q < NUM_REGS_C) ? XFER : DONE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      o_busy  = 1'b0;
      o_m_en  = 1'b0;
      o_done  = 1'b0;
      o_error = 1'b0;
      case (state_q)
         XFER: begin
            o_busy = 1'b1;
            o_m_en = 1'b1;
         end
         GAP:     o_busy  = 1'b1;
         DONE:    o_done  = 1'b1;
         ERROR:   o_error = 1'b1;
         default: ;
      endcase
   end

   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      rom_addr_d  = rom_addr_q;
      byte_cnt_d  = byte_cnt_q;
      reg_cnt_d   = reg_cnt_q;
      retry_cnt_d = retry_cnt_q;
      wdog_d      = '0;
      gap_d       = '0;
      last_d      = 1'b0;
      case (state_q)
         IDLE, DONE, ERROR: begin
            if (i_start) begin
               rom_addr_d  = '0;
               byte_cnt_d  = '0;
               reg_cnt_d   = '0;
               retry_cnt_d = '0;
            end
         end
         XFER: begin
            if (i_ack) begin
               rom_addr_d = rom_addr_q + 1'b1;
               if (entry_end) begin
                  byte_cnt_d  = '0;
                  reg_cnt_d   = reg_cnt_q + 1'b1;
                  retry_cnt_d = '0;
                  last_d      = 1'b1;
               end else begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
               end
            end else if (timeout) begin
               rom_addr_d  = rewind_addr;
               byte_cnt_d  = '0;
               retry_cnt_d = retry_cnt_q + 1'b1;
               last_d      = 1'b1;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         GAP: if (!gap_end) gap_d = gap_q + 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge r_sysclk or posedge r_arst) begin
      if (r_arst) begin
         rom_addr_q  <= '0;
         byte_cnt_q  <= '0;
         reg_cnt_q   <= '0;
         retry_cnt_q <= '0;
         wdog_q      <= '0;
         gap_q       <= '0;
         last_q      <= 1'b0;
      end else begin
         rom_addr_q  <= rom_addr_d;
         byte_cnt_q  <= byte_cnt_d;
         reg_cnt_q   <= reg_cnt_d;
         retry_cnt_q <= retry_cnt_d;
         wdog_q      <= wdog_d;
         gap_q       <= gap_d;
         last_q      <= last_d;
      end
   end

   assign o_last     = last_q;
   assign o_rom_addr = rom_addr_q;
   assign o_reg_cnt  = reg_cnt_q;
   assign o_m_wr     = 1'b0;
   assign o_addr     = DEV_ADDR;
   assign o_data     = i_rom_data;

endmodule
